decode_stage: RTL

- RISC-V ID stage plus ID/EX pipeline register, directly upstream of register_file and downstream of the IF/ID register.
- Decodes the D-stage instruction, drives register_file read addresses, applies WB bypass and x0 rules, generates immediates and control, detects load-use hazards, and registers everything into E-stage outputs.
- Subset: lw, sw, R-type (add, sub, and, or, slt), addi/andi/ori/slti, beq, jal.

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/imm_gen.sv | 28 ++
 rtl/decode_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared decode constants for the RV32 integer subset handled by the ID stage:
// opcodes, ALU control codes, result-select codes and the immediate-format enum.
// No ports; imported by imm_gen and decode_stage.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_src_t;

    // funct3 -> ALU op for the operations shared by R-type and I-ALU.
    // Bit 3 of the result flags a supported funct3; sub is resolved by the caller.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return {1'b1, ALU_ADD};
            3'b111:  return {1'b1, ALU_AND};
            3'b110:  return {1'b1, ALU_OR};
            3'b010:  return {1'b1, ALU_SLT};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the immediate field of the selected format.
// Ports:
//   i_instr   [31:7]  instruction bits above the opcode
//   i_imm_src         immediate format (IMM_NONE yields 0, used for R-type/illegal)
//   o_imm_ext [XLEN]  sign-extended immediate, combinational
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_instr,
    input  imm_src_t        i_imm_src,
    output logic [XLEN-1:0] o_imm_ext
);

    always_comb begin
        case (i_imm_src)
            IMM_I:   o_imm_ext = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            IMM_S:   o_imm_ext = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   o_imm_ext = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                                  i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_J:   o_imm_ext = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                                  i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm_ext = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RISC-V ID stage with ID/EX pipeline register.
// Decodes instr_d, drives register-file read addresses, applies WB bypass and
// x0 rules, builds immediates and control, detects load-use hazards and
// registers the result into the E-stage outputs.
// Ports:
//   clk, rst                  clock / async active-high reset
//   instr_d, pc_d, pc_plus4_d, valid_d   D-stage instruction from IF/ID
//   a1, a2 / rd1, rd2         register-file read addresses / data
//   we_w, rd_w, result_w      write-back port, used for the WB bypass
//   flush_e                   kill the D instruction (taken branch/jump)
//   stall_fd                  load-use stall to PC and IF/ID
//   *_e                       registered E-stage control, data and addresses
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic            valid_d,
    output logic [RAW-1:0]  a1,
    output logic [RAW-1:0]  a2,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic            we_w,
    input  logic [RAW-1:0]  rd_w,
    input  logic [XLEN-1:0] result_w,
    input  logic            flush_e,
    output logic            stall_fd,
    output logic            reg_write_e,
    output logic            mem_write_e,
    output logic            jump_e,
    output logic            branch_e,
    output logic            alu_src_e,
    output logic [1:0]      result_src_e,
    output logic [2:0]      alu_ctrl_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [RAW-1:0]  rs1_e,
    output logic [RAW-1:0]  rs2_e,
    output logic [RAW-1:0]  rd_e,
    output logic            valid_e,
    output logic            illegal_e
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [3:0]      w_alu_f3;
    logic            w_reg_write;
    logic            w_mem_write;
    logic            w_jump;
    logic            w_branch;
    logic            w_alu_src;
    logic            w_illegal;
    logic [1:0]      w_result_src;
    logic [2:0]      w_alu_ctrl;
    imm_src_t        w_imm_src;
    logic [XLEN-1:0] w_imm_ext;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_bubble;

    assign w_opcode = instr_d[6:0];
    assign w_funct3 = instr_d[14:12];
    assign w_funct7 = instr_d[31:25];
    assign w_alu_f3 = alu_from_funct3(w_funct3);

    assign a1 = instr_d[19:15];
    assign a2 = instr_d[24:20];

    // The register file writes on the same edge we capture, so a WB write to
    // the address being read must be forwarded here. x0 always reads 0.
    assign w_rd1 = (a1 == '0) ? '0 : ((we_w && rd_w == a1) ? result_w : rd1);
    assign w_rd2 = (a2 == '0) ? '0 : ((we_w && rd_w == a2) ? result_w : rd2);

    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_jump       = 1'b0;
        w_branch     = 1'b0;
        w_alu_src    = 1'b0;
        w_result_src = RES_ALU;
        w_alu_ctrl   = ALU_ADD;
        w_imm_src    = IMM_NONE;
        w_illegal    = 1'b1;
        case (w_opcode)
            OP_LOAD: begin
                if (w_funct3 == 3'b010) begin
                    w_illegal    = 1'b0;
                    w_reg_write  = 1'b1;
                    w_result_src = RES_MEM;
                    w_alu_src    = 1'b1;
                    w_imm_src    = IMM_I;
                end
            end
            OP_STORE: begin
                if (w_funct3 == 3'b010) begin
                    w_illegal   = 1'b0;
                    w_mem_write = 1'b1;
                    w_alu_src   = 1'b1;
                    w_imm_src   = IMM_S;
                end
            end
            OP_R: begin
                // funct7 must be all-zero, except 0100000 which only exists as sub
                if (w_alu_f3[3] && (w_funct7 == 7'b0000000 ||
                                    (w_funct7 == 7'b0100000 && w_funct3 == 3'b000))) begin
                    w_illegal   = 1'b0;
                    w_reg_write = 1'b1;
                    w_alu_ctrl  = w_funct7[5] ? ALU_SUB : w_alu_f3[2:0];
                end
            end
            OP_I: begin
                if (w_alu_f3[3]) begin
                    w_illegal   = 1'b0;
                    w_reg_write = 1'b1;
                    w_alu_src   = 1'b1;
                    w_alu_ctrl  = w_alu_f3[2:0];
                    w_imm_src   = IMM_I;
                end
            end
            OP_BRANCH: begin
                if (w_funct3 == 3'b000) begin
                    w_illegal  = 1'b0;
                    w_branch   = 1'b1;
                    w_alu_ctrl = ALU_SUB;
                    w_imm_src  = IMM_B;
                end
            end
            OP_JAL: begin
                w_illegal    = 1'b0;
                w_reg_write  = 1'b1;
                w_jump       = 1'b1;
                w_result_src = RES_PC4;
                w_imm_src    = IMM_J;
            end
            default: ;
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr   (instr_d[31:7]),
        .i_imm_src (w_imm_src),
        .o_imm_ext (w_imm_ext)
    );

    // Only operands the instruction actually reads can cause a load-use stall.
    assign w_use_rs1 = (w_opcode != OP_JAL);
    assign w_use_rs2 = !(w_opcode == OP_I || w_opcode == OP_LOAD || w_opcode == OP_JAL);

    assign stall_fd = !rst && valid_e && (result_src_e == RES_MEM) && (rd_e != '0) &&
                      ((w_use_rs1 && a1 == rd_e) || (w_use_rs2 && a2 == rd_e));

    assign w_bubble = flush_e || stall_fd || !valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_bubble) begin
            reg_write_e  <= 1'b0;
            mem_write_e  <= 1'b0;
            jump_e       <= 1'b0;
            branch_e     <= 1'b0;
            alu_src_e    <= 1'b0;
            result_src_e <= RES_ALU;
            alu_ctrl_e   <= ALU_ADD;
            rd1_e        <= '0;
            rd2_e        <= '0;
            imm_ext_e    <= '0;
            pc_e         <= '0;
            pc_plus4_e   <= '0;
            rs1_e        <= '0;
            rs2_e        <= '0;
            rd_e         <= '0;
            valid_e      <= 1'b0;
            illegal_e    <= 1'b0;
        end else begin
            reg_write_e  <= w_reg_write;
            mem_write_e  <= w_mem_write;
            jump_e       <= w_jump;
            branch_e     <= w_branch;
            alu_src_e    <= w_alu_src;
            result_src_e <= w_result_src;
            alu_ctrl_e   <= w_alu_ctrl;
            rd1_e        <= w_rd1;
            rd2_e        <= w_rd2;
            imm_ext_e    <= w_imm_ext;
            pc_e         <= pc_d;
            pc_plus4_e   <= pc_plus4_d;
            rs1_e        <= a1;
            rs2_e        <= a2;
            rd_e         <= instr_d[11:7];
            valid_e      <= 1'b1;
            illegal_e    <= w_illegal;
        end
    end

endmodule
